// File: rtl/image_effect_ctrl.sv
// image_effect_ctrl: debounced key control of pending effect settings, committed to outputs on vs_in rise.
// Define KEY_REPEAT_EN to auto-repeat held up/down keys every REPEAT_CYCLES.
module image_effect_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1485000,
    parameter int STEP            = 8,
    parameter int REPEAT_CYCLES   = 44550000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       vs_in,
    output logic [3:0] state_current,
    output logic [8:0] bright_adjust_val,
    output logic [8:0] contrast_adjust_val,
    output logic [8:0] saturation_adjust_val,
    output logic [7:0] TH
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [10:0] D = 11'(STEP);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || STEP < 1 || STEP > 255) begin : g_bad_param
        $error("image_effect_ctrl: parameter out of range");
    end

    logic [2:0]    raw, sync1, sync2, deb, deb_q, press, ev;
    logic [DW-1:0] cnt [3];
    logic [3:0]    pend_mode;
    logic [8:0]    pend_b, pend_c, pend_s;
    logic [7:0]    pend_t;
    logic          vs_q, load;
    logic signed [10:0] delta, nb, nc, ns, nt;

    assign raw = {key_down, key_up, key_mode};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_q <= '1;
            for (int j = 0; j < 3; j++) cnt[j] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int j = 0; j < 3; j++) begin
                if (sync2[j] == deb[j]) cnt[j] <= '0;
                else if (cnt[j] == DB_LAST) begin
                    cnt[j] <= '0;
                    deb[j] <= sync2[j];
                end else cnt[j] <= cnt[j] + 1'b1;
            end
        end
    end

    assign press = deb_q & ~deb;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES);
    logic [RW-1:0] rep_cnt [2];
    logic [1:0]    rep;

    // rep_cnt equals hold length in cycles; restarts at 1 so later repeats are REPEAT_CYCLES apart
    always_comb begin
        rep = '0;
        for (int j = 0; j < 2; j++) rep[j] = !deb[j+1] && rep_cnt[j] == REP_LAST;
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n || deb[j+1]) rep_cnt[j] <= '0;
            else rep_cnt[j] <= rep[j] ? RW'(1) : rep_cnt[j] + 1'b1;
        end
    end

    assign ev = {press[2:1] | rep, press[0]};
`else
    assign ev = press;
`endif

    function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                                 input logic signed [10:0] lo,
                                                 input logic signed [10:0] hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    always_comb begin
        delta = ev[1] ? D : -D;
        nb = clamp($signed({{2{pend_b[8]}}, pend_b}) + delta, -11'sd255, 11'sd255);
        nc = clamp($signed({2'b00, pend_c}) + delta, 11'sd0, 11'sd511);
        ns = clamp($signed({{2{pend_s[8]}}, pend_s}) + delta, -11'sd255, 11'sd255);
        nt = clamp($signed({3'b000, pend_t}) + delta, 11'sd0, 11'sd255);
    end

    // Mode press takes priority; simultaneous up and down cancel out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_mode <= 4'b0000;
            pend_b    <= 9'd0;
            pend_c    <= 9'd256;
            pend_s    <= 9'd0;
            pend_t    <= 8'd64;
        end else if (ev[0]) begin
            pend_mode <= pend_mode == 4'b0000 ? 4'b0001 : {pend_mode[2:0], 1'b0};
        end else if (ev[1] ^ ev[2]) begin
            if (pend_mode[0]) pend_b <= nb[8:0];
            if (pend_mode[1]) pend_c <= nc[8:0];
            if (pend_mode[2]) pend_s <= ns[8:0];
            if (pend_mode[3]) pend_t <= nt[7:0];
        end
    end

    assign load = vs_in & ~vs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q                  <= 1'b0;
            state_current         <= 4'b0000;
            bright_adjust_val     <= 9'd0;
            contrast_adjust_val   <= 9'd256;
            saturation_adjust_val <= 9'd0;
            TH                    <= 8'd64;
        end else begin
            vs_q <= vs_in;
            if (load) begin
                state_current         <= pend_mode;
                bright_adjust_val     <= pend_b;
                contrast_adjust_val   <= pend_c;
                saturation_adjust_val <= pend_s;
                TH                    <= pend_t;
            end
        end
    end
endmodule

// File: tb/tb_image_effect_ctrl.sv
// tb_image_effect_ctrl: randomized key/vsync stimulus checked against an arithmetic model of the effect settings.
module tb_image_effect_ctrl;
    localparam int DB = 4;
    localparam int ST = 8;
    localparam int RP = 20;

    logic clk = 1'b0;
    logic rst_n, key_mode, key_up, key_down, vs_in;
    logic [3:0] state_current;
    logic [8:0] bright_adjust_val, contrast_adjust_val, saturation_adjust_val;
    logic [7:0] TH;

    int n_checks = 0;
    int n_fail = 0;
    int pm, pb, pc, ps, pt;
    int om, ob, oc, os, ot;

    image_effect_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP(ST), .REPEAT_CYCLES(RP)) dut (
        .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
        .vs_in(vs_in), .state_current(state_current), .bright_adjust_val(bright_adjust_val),
        .contrast_adjust_val(contrast_adjust_val), .saturation_adjust_val(saturation_adjust_val),
        .TH(TH)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    task automatic model_reset();
        pm = 0; pb = 0; pc = 256; ps = 0; pt = 64;
        om = 0; ob = 0; oc = 256; os = 0; ot = 64;
    endtask

    task automatic apply(input bit m, input bit u, input bit d);
        int dv;
        dv = u ? ST : -ST;
        if (m) pm = (pm + 1) % 5;
        else if (u != d) begin
            case (pm)
                1: pb = clampi(pb + dv, -255, 255);
                2: pc = clampi(pc + dv, 0, 511);
                3: ps = clampi(ps + dv, -255, 255);
                4: pt = clampi(pt + dv, 0, 255);
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, int'(state_current), om == 0 ? 0 : 1 << (om - 1));
        check({tag, ".bright"}, int'($signed(bright_adjust_val)), ob);
        check({tag, ".contrast"}, int'(contrast_adjust_val), oc);
        check({tag, ".sat"}, int'($signed(saturation_adjust_val)), os);
        check({tag, ".th"}, int'(TH), ot);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        model_reset();
    endtask

    task automatic vsync();
        vs_in = 1'b1;
        tick(2);
        vs_in = 1'b0;
        tick(3);
        om = pm; ob = pb; oc = pc; os = ps; ot = pt;
    endtask

    // Hold the chosen keys low for len cycles; a hold shorter than DB cycles is a glitch
    task automatic press(input bit m, input bit u, input bit d, input int len);
        key_mode = ~m; key_up = ~u; key_down = ~d;
        tick(len);
        key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
        tick(12);
        if (len >= DB) begin
            apply(m, u, d);
`ifdef KEY_REPEAT_EN
            if (u || d) for (int r = 0; r < (len - 1) / RP; r++) apply(1'b0, u, d);
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1; vs_in = 1'b0;
        model_reset();
        do_reset();
        check_all("reset");
        for (int i = 0; i < 3; i++) vsync();
        check_all("idle_vs");

        press(1'b1, 1'b0, 1'b0, 2);
        check("glitch_pend", int'(dut.pend_mode), 0);
        press(1'b1, 1'b0, 1'b0, 10);
        check_all("mode_before_vs");
        vsync();
        check_all("mode_after_vs");

        for (int i = 0; i < 33; i++) press(1'b0, 1'b1, 1'b0, 6);
        check_all("bright_hold");
        vsync();
        check_all("bright_max");
        for (int i = 0; i < 70; i++) press(1'b0, 1'b0, 1'b1, 6);
        vsync();
        check_all("bright_min");

        do_reset();
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b1, 7);
        vsync();
        check_all("updown_same");
        press(1'b1, 1'b1, 1'b0, 7);
        vsync();
        check_all("mode_up_same");

        do_reset();
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 6);
        do_reset();
        check_all("th_reset");
        vsync();
        check_all("th_reset_vs");

        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 6))
                0: press(1'b1, 1'b0, 1'b0, $urandom_range(5, 12));
                1: press(1'b0, 1'b1, 1'b0, $urandom_range(5, 12));
                2: press(1'b0, 1'b0, 1'b1, $urandom_range(5, 12));
                3: vsync();
                4: press(1'b0, 1'b1, 1'b1, $urandom_range(5, 12));
                5: press(1'b1, 1'b1, 1'b0, $urandom_range(5, 12));
                default: press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 2);
            endcase
            check_all("rand");
        end
        vsync();
        check_all("rand_final");

        do_reset();
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 100);
        vsync();
`ifdef KEY_REPEAT_EN
        check("hold_bright_const", int'($signed(bright_adjust_val)), 40);
`else
        check("hold_bright_const", int'($signed(bright_adjust_val)), 8);
`endif
        check_all("hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/image_effect_ctrl.md
IMAGE_EFFECT_CTRL -- requirements
Module: image_effect_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1485000: clk cycles a raw key must stay stable to be accepted (10 ms at 148.5 MHz).
REQ-002 Parameter STEP, default 8: increment/decrement applied per accepted up/down press.
REQ-003 Parameter REPEAT_CYCLES, default 44550000: hold time before the first auto-repeat step, and the interval between later repeat steps (used only under KEY_REPEAT_EN).
REQ-004 clk  input  1  pixel clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 key_mode, key_up, key_down  input  1 each  raw push-buttons, active-low, asynchronous to clk.
REQ-007 vs_in  input  1  video vertical sync, active-high, same clk domain.
REQ-008 state_current  output  4  effect select, one of 0000/0001/0010/0100/1000.
REQ-009 bright_adjust_val  output  9  signed two's complement, -255..+255.
REQ-010 contrast_adjust_val  output  9  unsigned 0..511, 256 = unity gain.
REQ-011 saturation_adjust_val  output  9  signed two's complement, -255..+255.
REQ-012 TH  output  8  relief threshold, unsigned 0..255.

Function
REQ-013 Each key SHALL pass a 2-flop synchronizer and then a debounce counter; the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 A press event SHALL be a single-cycle pulse on the 1->0 transition of a debounced level.
REQ-015 Each mode press SHALL advance pending_mode 0000->0001->0010->0100->1000->0000, wrapping.
REQ-016 Up/down press SHALL add/subtract STEP to the pending value selected by pending_mode: 0001 bright, 0010 contrast, 0100 saturation, 1000 TH; 0000 SHALL ignore up/down.
REQ-017 Arithmetic SHALL use at least 11-bit intermediate width and saturate: bright/saturation to [-255,+255]; contrast to [0,511]; TH to [0,255]; no wrap-around.
REQ-018 Up and down press in the same cycle SHALL both be ignored; a mode press in the same cycle as up/down SHALL win, and up/down SHALL be ignored.
REQ-019 Outputs SHALL load all pending registers together on the clock edge following the first cycle in which vs_in is sampled 1 after being sampled 0 (frame-synchronous update, no tearing); outputs SHALL hold at all other times.
REQ-020 Pending values of non-selected effects SHALL be retained across mode changes.
REQ-021 Press-to-pending latency SHALL be 1 cycle after the press pulse.

Reset
REQ-022 While rst_n=0 at a clk edge: state_current=0000, bright=0, contrast=256, saturation=0, TH=64; pending registers take the same values; debounced levels=1; debounce and repeat counters=0; vs edge register=0.
REQ-023 Reset asserted mid-debounce or mid-frame SHALL discard partial counts and pending edits; no press is generated on release of reset, even when a key is held.

Configuration
REQ-024 Macro KEY_REPEAT_EN: when defined, a debounced up/down held low SHALL generate one extra press event after REPEAT_CYCLES of hold, then one every REPEAT_CYCLES until release; key_mode SHALL never repeat.
REQ-025 Without KEY_REPEAT_EN: exactly one event per press regardless of hold time; the repeat counter logic SHALL be absent.

Verification (DEBOUNCE_CYCLES=4, STEP=8, REPEAT_CYCLES=20)
REQ-026 Reset release, no keys, 3 vs_in pulses -> outputs stay 0000/0/256/0/64.
REQ-027 key_mode low for 2 cycles (glitch) -> no press; key_mode low for 10 cycles -> pending_mode=0001; state_current stays 0000 until next vs_in rise, then 0001.
REQ-028 In mode 0001, 33 up presses then vs_in rise -> bright_adjust_val=+255 (0x0FF); 70 down presses -> -255 (0x101), no wrap.
REQ-029 Mode 0010, up and down pressed in same cycle -> contrast unchanged at 256; mode+up in same cycle -> mode advances to 0100, saturation unchanged.
REQ-030 Mode 1000, 2 up presses, rst_n pulsed low before vs_in -> TH=64 after reset and after the next vs_in rise.
REQ-031 KEY_REPEAT_EN defined, mode 0001, key_up held 100 cycles -> 1 + 4 events, bright=+40 after vs_in; macro undefined -> bright=+8.
